// File: rtl/dcache_controller.sv
// ---------------------------------------------------------------------------
// dcache_controller
//   Controller for a 2-set, 2-way, 16-byte-line write-back data cache.
//   Line id = {index, way}; per line: valid, dirty, tag. One LRU bit per set.
//   Lookup in IDLE is combinational so hits complete with stall=0 in the same
//   cycle. Misses write back a dirty victim (WRITEBACK) and then fetch the
//   line word by word (REFILL); the held CPU request then replays as a hit.
//
//   Build option: define DCACHE_PERF_CNT_EN to enable saturating hit/miss
//   counters; when undefined, hit_count/miss_count are tied to 0.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cpu_re, cpu_we        CPU load/store (held until stall=0), cpu_addr byte addr
//   stall                 CPU must hold its request
//   re, we, hit, first, second, index, copy_back, cache_data_src,
//   w_sel, copy           data-array controls (copy = {index,way} for copy-back)
//   mem_re, mem_we, mem_addr, mem_ready   word-wide memory handshake
//   hit_count, miss_count performance counters
// ---------------------------------------------------------------------------
module dcache_controller #(
    parameter int TAG_W = 27,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_re,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    output logic             stall,
    output logic             re,
    output logic             we,
    output logic             hit,
    output logic             first,
    output logic             second,
    output logic             index,
    output logic             copy_back,
    output logic             cache_data_src,
    output logic [1:0]       w_sel,
    output logic [1:0]       copy,
    output logic             mem_re,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    state_t           state;
    logic [3:0]       valid;
    logic [3:0]       dirty;
    logic [TAG_W-1:0] tags [4];
    logic [1:0]       lru;        // per set: the least recently used way
    logic [1:0]       wcnt;       // word within the line being moved
    logic [TAG_W-1:0] lat_tag;
    logic             lat_set;
    logic             victim;

    logic             req, rd, wr, set;
    logic [TAG_W-1:0] tag;
    logic             hit0, hit1, lookup_hit, vict_sel;
    logic             unused_addr;

    // A simultaneous load and store is handled purely as a load.
    assign req  = cpu_re | cpu_we;
    assign rd   = cpu_re;
    assign wr   = cpu_we & ~cpu_re;
    assign set  = cpu_addr[4];
    assign tag  = cpu_addr[5 +: TAG_W];
    assign unused_addr = ^cpu_addr[1:0];

    assign hit0       = valid[{set, 1'b0}] && (tags[{set, 1'b0}] == tag);
    assign hit1       = valid[{set, 1'b1}] && (tags[{set, 1'b1}] == tag);
    assign lookup_hit = hit0 | hit1;

    // Fill an empty way first (way0 preferred), otherwise evict the LRU way.
    assign vict_sel = !valid[{set, 1'b0}] ? 1'b0 :
                      !valid[{set, 1'b1}] ? 1'b1 : lru[set];

    // Outputs are combinational so IDLE hits finish in a single cycle; all
    // are forced low while reset is asserted.
    always_comb begin
        stall = 1'b0; re = 1'b0; we = 1'b0; hit = 1'b0;
        first = 1'b0; second = 1'b0; index = 1'b0;
        copy_back = 1'b0; cache_data_src = 1'b0;
        w_sel = 2'b00; copy = 2'b00;
        mem_re = 1'b0; mem_we = 1'b0; mem_addr = 32'h0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    index = set;
                    if (req) begin
                        first  = hit0;
                        second = hit1;
                        if (lookup_hit) begin
                            hit   = 1'b1;
                            re    = rd;
                            we    = wr;
                            w_sel = cpu_addr[3:2];
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    stall     = 1'b1;
                    index     = lat_set;
                    copy_back = 1'b1;
                    copy      = {lat_set, victim};
                    w_sel     = wcnt;
                    mem_we    = 1'b1;
                    mem_addr  = 32'({tags[{lat_set, victim}], lat_set, wcnt, 2'b00});
                end
                REFILL: begin
                    stall    = 1'b1;
                    index    = lat_set;
                    mem_re   = 1'b1;
                    mem_addr = 32'({lat_tag, lat_set, wcnt, 2'b00});
                    if (mem_ready) begin
                        we             = 1'b1;
                        cache_data_src = 1'b1;
                        w_sel          = wcnt;
                        first          = ~victim;
                        second         = victim;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            valid   <= '0;
            dirty   <= '0;
            lru     <= '0;
            wcnt    <= '0;
            lat_tag <= '0;
            lat_set <= 1'b0;
            victim  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (lookup_hit) begin
                            lru[set] <= hit0;  // other way becomes LRU
                            if (wr) dirty[{set, hit1}] <= 1'b1;
                        end else begin
                            lat_tag <= tag;
                            lat_set <= set;
                            victim  <= vict_sel;
                            wcnt    <= 2'd0;
                            // The victim stops matching immediately so an
                            // aborted refill never leaves a half-filled line valid.
                            valid[{set, vict_sel}] <= 1'b0;
                            dirty[{set, vict_sel}] <= 1'b0;
                            state <= (valid[{set, vict_sel}] && dirty[{set, vict_sel}])
                                     ? WRITEBACK : REFILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        wcnt <= wcnt + 2'd1;
                        if (wcnt == 2'd3) state <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        wcnt <= wcnt + 2'd1;
                        if (wcnt == 2'd3) begin
                            tags[{lat_set, victim}]  <= lat_tag;
                            valid[{lat_set, victim}] <= 1'b1;
                            dirty[{lat_set, victim}] <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && req) begin
            if (lookup_hit) begin
                if (hit_count != '1) hit_count <= hit_count + 1'b1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 1'b1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

    logic        clk, reset, cpu_re, cpu_we, mem_ready;
    logic [31:0] cpu_addr;
    logic        stall, re, we, hit, first, second, index, copy_back, cache_data_src;
    logic [1:0]  w_sel, copy;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr;
    logic [15:0] hit_count, miss_count;

    int passed = 0;
    int total  = 0;

    dcache_controller #(.TAG_W(27), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .stall(stall), .re(re), .we(we), .hit(hit), .first(first), .second(second),
        .index(index), .copy_back(copy_back), .cache_data_src(cache_data_src),
        .w_sel(w_sel), .copy(copy), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a request that must miss; leaves the controller one edge later.
    task automatic start_miss(input logic [31:0] a, input string name);
        cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        #1;
        total++;
        if ({stall, hit, mem_re, mem_we} !== 4'b1000)
            $display("FAIL %s_miss: stall/hit/mem_re/mem_we=%b want 1000", name,
                     {stall, hit, mem_re, mem_we});
        else passed++;
        step();
    endtask

    // Services n refill words with mem_ready one cycle after each request.
    task automatic do_refill(input logic [31:0] base, input logic way, input int n);
        for (int w = 0; w < n; w++) begin
            total++;
            if ({mem_re, mem_we, stall, mem_addr} !== {1'b1, 1'b0, 1'b1, base + 32'(w * 4)})
                $display("FAIL refill_req%0d: re/we/stall/addr=%b/%b/%b/%h want 1/0/1/%h",
                         w, mem_re, mem_we, stall, mem_addr, base + 32'(w * 4));
            else passed++;
            mem_ready = 1'b1;
            #1;
            total++;
            if ({we, hit, cache_data_src, first, second, w_sel, stall} !==
                {1'b1, 1'b0, 1'b1, ~way, way, 2'(w), 1'b1})
                $display("FAIL refill_ack%0d: we/hit/src/first/second/wsel/stall=%b want %b", w,
                         {we, hit, cache_data_src, first, second, w_sel, stall},
                         {1'b1, 1'b0, 1'b1, ~way, way, 2'(w), 1'b1});
            else passed++;
            step();
            mem_ready = 1'b0;
            #1;
        end
    endtask

    task automatic do_writeback(input logic [31:0] base, input logic [1:0] cp);
        for (int w = 0; w < 4; w++) begin
            total++;
            if ({mem_we, mem_re, copy_back, copy, w_sel, stall, mem_addr} !==
                {1'b1, 1'b0, 1'b1, cp, 2'(w), 1'b1, base + 32'(w * 4)})
                $display("FAIL wb_word%0d: we/re/cb/copy/wsel/stall=%b addr=%h want %b addr=%h", w,
                         {mem_we, mem_re, copy_back, copy, w_sel, stall}, mem_addr,
                         {1'b1, 1'b0, 1'b1, cp, 2'(w), 1'b1}, base + 32'(w * 4));
            else passed++;
            mem_ready = 1'b1;
            step();
            mem_ready = 1'b0;
            #1;
        end
    endtask

    task automatic check_replay(input logic way, input logic [1:0] ws, input string name);
        total++;
        if ({re, we, hit, stall, first, second, w_sel, mem_re, mem_we} !==
            {1'b1, 1'b0, 1'b1, 1'b0, ~way, way, ws, 1'b0, 1'b0})
            $display("FAIL %s_replay: re/we/hit/stall/first/second/wsel/mre/mwe=%b want %b", name,
                     {re, we, hit, stall, first, second, w_sel, mem_re, mem_we},
                     {1'b1, 1'b0, 1'b1, 1'b0, ~way, way, ws, 1'b0, 1'b0});
        else passed++;
        step();
        cpu_re = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; mem_ready = 1'b1;
        step(); step();
        total++;
        if ({stall, re, we, hit, first, second, index, copy_back, cache_data_src, w_sel, copy,
             mem_re, mem_we, mem_addr, hit_count, miss_count} !== '0)
            $display("FAIL reset_outputs: stall=%b mem_re=%b mem_we=%b mem_addr=%h hc=%0d mc=%0d want all 0",
                     stall, mem_re, mem_we, mem_addr, hit_count, miss_count);
        else passed++;
        reset = 1'b0; cpu_re = 1'b0; mem_ready = 1'b0;
        step();
    endtask

    task automatic test_read_refill();
        start_miss(32'h10, "rd10");
        do_refill(32'h10, 1'b0, 4);
        check_replay(1'b0, 2'b00, "rd10");
    endtask

    task automatic test_store_hit();
        cpu_we = 1'b1; cpu_addr = 32'h14;
        #1;
        total++;
        if ({we, hit, cache_data_src, stall, re, first, w_sel, mem_re, mem_we} !== 10'b1100010100)
            $display("FAIL store_hit: we/hit/src/stall/re/first/wsel/mre/mwe=%b want 1100010100",
                     {we, hit, cache_data_src, stall, re, first, w_sel, mem_re, mem_we});
        else passed++;
        step();
        cpu_we = 1'b0;
    endtask

    task automatic test_writeback();
        logic [15:0] eh, em;
        start_miss(32'h30, "rd30");
        do_refill(32'h30, 1'b1, 4);
        check_replay(1'b1, 2'b00, "rd30");
`ifdef DCACHE_PERF_CNT_EN
        eh = 16'd3; em = 16'd2;
`else
        eh = 16'd0; em = 16'd0;
`endif
        total++;
        if ({hit_count, miss_count} !== {eh, em})
            $display("FAIL perf_counters: hit=%0d miss=%0d want %0d/%0d",
                     hit_count, miss_count, eh, em);
        else passed++;
        start_miss(32'h50, "rd50");
        do_writeback(32'h10, 2'b10);
        do_refill(32'h50, 1'b0, 4);
        check_replay(1'b0, 2'b00, "rd50");
    endtask

    task automatic test_read_write_both();
        cpu_re = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h50;
        #1;
        total++;
        if ({re, we, hit, stall, first} !== 5'b10101)
            $display("FAIL rw_both: re/we/hit/stall/first=%b want 10101", {re, we, hit, stall, first});
        else passed++;
        step();
        cpu_we = 1'b0; cpu_addr = 32'h30;
        #1;
        total++;
        if ({hit, second, stall} !== 3'b110)
            $display("FAIL rd30_hit: hit/second/stall=%b want 110", {hit, second, stall});
        else passed++;
        step();
        // Way0 (0x50) is now LRU; it must be clean, so the miss goes straight to REFILL.
        start_miss(32'h70, "rd70");
        total++;
        if ({mem_re, mem_we, copy_back, mem_addr} !== {3'b100, 32'h70})
            $display("FAIL clean_victim: mre/mwe/cb=%b addr=%h want 100 addr=00000070",
                     {mem_re, mem_we, copy_back}, mem_addr);
        else passed++;
        do_refill(32'h70, 1'b0, 4);
        check_replay(1'b0, 2'b00, "rd70");
    endtask

    task automatic test_reset_abort();
        start_miss(32'h10, "abort");
        do_refill(32'h10, 1'b1, 2);
        total++;
        if ({mem_re, mem_addr} !== {1'b1, 32'h18})
            $display("FAIL abort_word2: mem_re=%b addr=%h want 1 addr=00000018", mem_re, mem_addr);
        else passed++;
        reset = 1'b1; cpu_re = 1'b0; mem_ready = 1'b1;
        #1;
        total++;
        if ({stall, mem_re, mem_we, we} !== 4'b0000)
            $display("FAIL abort_during_reset: stall/mre/mwe/we=%b want 0000", {stall, mem_re, mem_we, we});
        else passed++;
        step();
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        total++;
        if ({stall, mem_re, mem_we, hit_count, miss_count} !== '0)
            $display("FAIL abort_idle: stall/mre/mwe=%b hc=%0d mc=%0d want 000 0 0",
                     {stall, mem_re, mem_we}, hit_count, miss_count);
        else passed++;
        start_miss(32'h10, "after_abort");
        total++;
        if ({mem_re, mem_we, mem_addr} !== {2'b10, 32'h10})
            $display("FAIL after_abort_refill: mre/mwe=%b addr=%h want 10 addr=00000010",
                     {mem_re, mem_we}, mem_addr);
        else passed++;
        reset = 1'b1; cpu_re = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; mem_ready = 1'b0;
        test_reset();
        test_read_refill();
        test_store_hit();
        test_writeback();
        test_read_write_both();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 Parameter TAG_W, default 27, tag width (addr[31:5]).
REQ-002 Parameter CNT_W, default 16, width of performance counters.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 cpu_re / cpu_we  in  1 each  CPU load / store request, held until stall=0.
REQ-007 cpu_addr  in  32  byte address: offset=[3:0], index=[4], tag=[31:5].
REQ-008 stall  out  1  CPU must hold the request while high.
REQ-009 re, we, hit, first, second, index, copy_back, cache_data_src  out  1 each  data cache controls.
REQ-010 w_sel  out  2  and  copy  out  2  are the cache word select and copy-back line select ({index,way}).
REQ-011 mem_re, mem_we  out  1  and  mem_addr  out  32  form the word-wide memory request.
REQ-012 mem_ready  in  1  memory acknowledges the current word.
REQ-013 hit_count, miss_count  out  CNT_W  performance counters.

Function
REQ-014 Internal state per line (4 lines, {index,way}): valid, dirty, TAG_W tag; one LRU bit per set, naming the LRU way.
REQ-015 FSM states: IDLE, WRITEBACK, REFILL; reset state IDLE.
REQ-016 IDLE lookup is combinational: hit when a valid line in set cpu_addr[4] matches the tag; first=way0 hit, second=way1 hit.
REQ-017 Read hit in IDLE: re=1, hit=1, w_sel=cpu_addr[3:2], stall=0 in the same cycle; LRU updated to the other way at the edge.
REQ-018 Write hit in IDLE: we=1, hit=1, cache_data_src=0, stall=0; line dirty=1 and LRU updated at the edge.
REQ-019 cpu_re and cpu_we both high: treated as a read; the write is ignored.
REQ-020 Miss: stall=1; latch address; victim = invalid way (way0 preferred), else LRU way; next state WRITEBACK if victim valid and dirty, else REFILL.
REQ-021 WRITEBACK: for w=0..3: copy_back=1, copy={index,victim}, w_sel=w, mem_we=1, mem_addr={victim tag,index,w,2'b00}; advance w only on mem_ready; after w=3 acknowledged, go to REFILL.
REQ-022 REFILL: for w=0..3: mem_re=1, mem_addr={tag,index,w,2'b00}; in the mem_ready cycle: we=1, hit=0, cache_data_src=1, w_sel=w, first/second select the victim.
REQ-023 After w=3 is acknowledged: tag written, valid=1, dirty=0, go to IDLE; the held request then replays as a hit; stall stays 1 through the final REFILL cycle.
REQ-024 mem_re and mem_we are never high together; neither is high in IDLE.
REQ-025 mem_ready outside WRITEBACK or REFILL is ignored; no timeout.
REQ-026 Word counter wraps 3 to 0 only on a state exit.

Reset
REQ-027 On reset: state=IDLE; all valid, dirty and LRU bits 0; word counter 0; counters 0.
REQ-028 On reset: all outputs 0, including stall, mem_re, mem_we and mem_addr.
REQ-029 Reset during WRITEBACK or REFILL aborts at that edge; memory requests drop in the next cycle; partially refilled lines stay invalid.

Configuration
REQ-030 Macro DCACHE_PERF_CNT_EN defined: hit_count increments once per IDLE hit; miss_count increments once per miss detection; both saturate at all-ones.
REQ-031 Macro DCACHE_PERF_CNT_EN undefined: counter logic is omitted and hit_count and miss_count are tied to 0; all other behaviour is identical.

Verification
REQ-032 Read 0x00000010 after reset, mem_ready one cycle after each request -> 4 REFILL words at 0x10, 0x14, 0x18, 0x1C; then re=1, hit=1, stall=0.
REQ-033 Store to 0x00000014 after that refill -> hit with one-cycle stall=0; line {1,0} marked dirty.
REQ-034 Reads to 0x30 and then 0x50 (set 1, third tag) -> dirty victim 0x10 is written back to 0x10..0x1C with copy=2'b10, then 0x50..0x5C is refilled.
REQ-035 Assert reset during the 3rd REFILL word -> at the next edge state=IDLE, stall=0; the next access to that address misses.
REQ-036 cpu_re=cpu_we=1 on a hit -> re=1, we=0; dirty bit unchanged.
REQ-037 With DCACHE_PERF_CNT_EN, after 3 hits and 2 misses -> hit_count=3 (replays included), miss_count=2; without the macro both read 0.
